// File: rtl/matrix_scan_ctrl_if.sv
// Render-side port of the LED matrix scan controller: back-bank row writes,
// bank swap request/acknowledge and the frame-start marker.
interface matrix_scan_ctrl_if #(
  parameter int unsigned COLS = 16
);
  logic            wr_en;
  logic [2:0]      wr_row;
  logic [COLS-1:0] wr_data;
  logic            swap_req;
  logic            swap_ack;
  logic            frame_start;

  modport master (
    output wr_en, wr_row, wr_data, swap_req,
    input  swap_ack, frame_start
  );

  modport slave (
    input  wr_en, wr_row, wr_data, swap_req,
    output swap_ack, frame_start
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Row-multiplexed LED matrix scanner with double-buffered framebuffer.
// Banks exchange only at the frame boundary so a partial frame is never shown.
module matrix_scan_ctrl #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 16,
  parameter int unsigned DWELL = 1024,
  parameter int unsigned BLANK = 16
) (
  input  logic                clk,
  input  logic                reset,
  matrix_scan_ctrl_if.slave   bus,
  output logic [7:0]          MATRIX_ROW,
  output logic [COLS-1:0]     MATRIX_COL
);

  localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       row, row_nxt;
  logic             bank_sel, bank_sel_nxt;
  logic             pending, pending_nxt;
  logic             swap_c;
  logic             wr_hit_c;
  logic [7:0]       row_drv_nxt;
  logic [COLS-1:0]  col_drv_nxt;
  logic             frame_start_nxt;

  logic [COLS-1:0]  bank [2][ROWS];

  assign wr_hit_c = bus.wr_en && ({1'b0, bus.wr_row} < 4'(ROWS));

  // Scan sequencing, swap decision and next pin values
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt + 1'b1;
    row_nxt         = row;
    bank_sel_nxt    = bank_sel;
    pending_nxt     = pending | bus.swap_req;
    swap_c          = 1'b0;
    row_drv_nxt     = 8'hFF;
    col_drv_nxt     = '1;
    frame_start_nxt = 1'b0;

    case (state)
      S_BLANK: begin
        frame_start_nxt = (row == 3'd0) && (cnt == '0);
        if (cnt == CNT_W'(BLANK - 1)) begin
          state_nxt = S_ON;
          cnt_nxt   = '0;
        end
      end
      S_ON: begin
        row_drv_nxt = ~(8'd1 << row);
        col_drv_nxt = ~bank[bank_sel][row];
        if (cnt == CNT_W'(DWELL - 1)) begin
          state_nxt = S_BLANK;
          cnt_nxt   = '0;
          if (row == 3'(ROWS - 1)) begin
            // Frame boundary: the only point where the banks may exchange
            row_nxt = 3'd0;
            if (pending_nxt) begin
              swap_c       = 1'b1;
              bank_sel_nxt = ~bank_sel;
              pending_nxt  = 1'b0;
            end
          end else begin
            row_nxt = row + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_BLANK;
      cnt             <= '0;
      row             <= 3'd0;
      bank_sel        <= 1'b0;
      pending         <= 1'b0;
      MATRIX_ROW      <= 8'hFF;
      MATRIX_COL      <= '1;
      bus.swap_ack    <= 1'b0;
      bus.frame_start <= 1'b0;
      for (int r = 0; r < int'(ROWS); r++) begin
        bank[0][r] <= '0;
        bank[1][r] <= '0;
      end
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      row             <= row_nxt;
      bank_sel        <= bank_sel_nxt;
      pending         <= pending_nxt;
      MATRIX_ROW      <= row_drv_nxt;
      MATRIX_COL      <= col_drv_nxt;
      bus.swap_ack    <= swap_c;
      bus.frame_start <= frame_start_nxt;
      // Writes go to the bank not currently selected for display
      if (wr_hit_c) begin
        bank[~bank_sel][bus.wr_row] <= bus.wr_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Randomized bench for matrix_scan_ctrl; expected pins are derived from the
// cycle position within the frame and a two-bank framebuffer model.
module tb_matrix_scan_ctrl;

  localparam int unsigned ROWS  = 6;
  localparam int unsigned COLS  = 16;
  localparam int unsigned DWELL = 4;
  localparam int unsigned BLANK = 2;
  localparam int          RP    = BLANK + DWELL;
  localparam int          FP    = ROWS * RP;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0]      matrix_row;
  logic [COLS-1:0] matrix_col;

  matrix_scan_ctrl_if #(.COLS(COLS)) bus ();

  matrix_scan_ctrl #(
    .ROWS (ROWS),
    .COLS (COLS),
    .DWELL(DWELL),
    .BLANK(BLANK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .MATRIX_ROW(matrix_row),
    .MATRIX_COL(matrix_col)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acks_seen = 0;

  // Reference state: two banks, displayed-bank select, pending flag, cycle index
  logic [COLS-1:0] mbank [2][ROWS];
  logic            msel;
  logic            mpend;
  int              s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < int'(ROWS); r++) begin
      mbank[0][r] = '0;
      mbank[1][r] = '0;
    end
    msel  = 1'b0;
    mpend = 1'b0;
    s     = 0;
  endtask

  // Called at a negedge: drive inputs, predict, clock, check, return at next negedge
  task automatic step(input logic we, input logic [2:0] wr, input logic [COLS-1:0] wd,
                      input logic sr);
    int              p, r, off;
    logic [7:0]      exp_row;
    logic [COLS-1:0] exp_col;
    logic            exp_fs, exp_ack;
    bus.wr_en    = we;
    bus.wr_row   = wr;
    bus.wr_data  = wd;
    bus.swap_req = sr;
    p   = s % FP;
    r   = p / RP;
    off = p % RP;
    if (off >= int'(BLANK)) begin
      exp_row = ~(8'd1 << r);
      exp_col = ~mbank[msel][r];
    end else begin
      exp_row = 8'hFF;
      exp_col = '1;
    end
    exp_fs = (p == 0);
    if (we && int'(wr) < int'(ROWS)) mbank[!msel][wr] = wd;
    mpend   = mpend | sr;
    exp_ack = 1'b0;
    if (p == FP - 1 && mpend) begin
      msel    = !msel;
      mpend   = 1'b0;
      exp_ack = 1'b1;
    end
    s++;
    @(posedge clk);
    #1;
    check("row", 32'(matrix_row), 32'(exp_row));
    check("col", 32'(matrix_col), 32'(exp_col));
    check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    check("swap_ack", 32'(bus.swap_ack), 32'(exp_ack));
    if (bus.swap_ack) acks_seen++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0, 1'b0);
  endtask

  task automatic rand_steps(input int n, input int p_wr, input int p_swap);
    for (int i = 0; i < n; i++)
      step(($urandom_range(99) < p_wr), 3'($urandom_range(7)), COLS'($urandom),
           ($urandom_range(99) < p_swap));
  endtask

  initial begin
    reset        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_row   = 3'd0;
    bus.wr_data  = '0;
    bus.swap_req = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_row", 32'(matrix_row), 32'hFF);
    check("rst_col", 32'(matrix_col), 32'(16'hFFFF));
    check("rst_ack", 32'(bus.swap_ack), 32'd0);
    check("rst_fs", 32'(bus.frame_start), 32'd0);
    reset = 1'b0;

    // Idle scan over cleared banks
    idle(2 * FP);

    // Row 3 pattern then a one-cycle swap request
    step(1'b1, 3'd3, 16'h8001, 1'b0);
    step(1'b0, 3'd0, '0, 1'b1);
    idle(2 * FP);

    // Back-bank write without swap, plus an out-of-range row write
    step(1'b1, 3'd2, 16'h00FF, 1'b0);
    step(1'b1, 3'd7, 16'h1234, 1'b0);
    idle(3 * FP);

    // Held swap request for three aligned frames
    while (s % FP != 0) idle(1);
    acks_seen = 0;
    for (int i = 0; i < 3 * FP; i++) step(1'b0, 3'd0, '0, 1'b1);
    check("held_swap_acks", 32'(acks_seen), 32'd3);

    // Random traffic
    rand_steps(10 * FP, 30, 10);
    rand_steps(4 * FP, 60, 50);

    // Asynchronous reset in the middle of row 4 lit phase
    while ((s - 1) % FP != 4 * RP + int'(BLANK) + 1) idle(1);
    check("pre_rst_row4", 32'(matrix_row), 32'hEF);
    reset = 1'b1;
    #1;
    check("async_rst_row", 32'(matrix_row), 32'hFF);
    check("async_rst_col", 32'(matrix_col), 32'(16'hFFFF));
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(FP);
    step(1'b0, 3'd0, '0, 1'b1);
    idle(FP);
    rand_steps(3 * FP, 40, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
